// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port instruction-memory arbiter.
package mem_arb_pkg;

    localparam int AW_DEF = 8;
    localparam int DW_DEF = 15;

    typedef enum logic {
        PORT_CPU  = 1'b0,
        PORT_HOST = 1'b1
    } port_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CPU  = 2'd1,
        HOST = 2'd2,
        LOCK = 2'd3
    } arb_state_e;

    typedef struct packed {
        logic  valid;
        port_e port;
        logic  is_read;
    } tag_t;

    function automatic port_e other_port(input port_e p);
        return (p == PORT_CPU) ? PORT_HOST : PORT_CPU;
    endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection: lock forces host, contention goes to the port the pointer names.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic  cpu_req,
    input  logic  host_req,
    input  logic  host_lock,
    input  port_e pointer,
    output logic  sel_cpu,
    output logic  sel_host
);

    always_comb begin
        sel_cpu  = 1'b0;
        sel_host = 1'b0;
        if (host_lock) begin
            sel_host = 1'b1;
        end else if (cpu_req && host_req) begin
            sel_cpu  = (pointer == PORT_CPU);
            sel_host = (pointer == PORT_HOST);
        end else begin
            sel_cpu  = cpu_req;
            sel_host = host_req;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates cpu and host-loader access to one synchronous memory; round-robin when
// MEM_ARB_RR_EN is defined, otherwise fixed priority with host over cpu.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_adr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_adr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic          host_rvalid,
    input  logic          host_lock,
    output logic          cpu_stall,
    output logic [DW-1:0] rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output arb_state_e    state
);

    // Handshake: a request transfers in the cycle where x_req and x_gnt are both high;
    // the requester keeps its command stable until then and may withdraw it at any time.
    logic          sel_cpu;
    logic          sel_host;
    port_e         pointer;
    logic          accept;
    port_e         acc_port;
    logic          acc_we;
    logic [AW-1:0] acc_adr;
    logic [DW-1:0] acc_wdata;
    tag_t          tag0;
    tag_t          tag1;

    arb_pick u_pick (
        .cpu_req   (cpu_req),
        .host_req  (host_req),
        .host_lock (host_lock),
        .pointer   (pointer),
        .sel_cpu   (sel_cpu),
        .sel_host  (sel_host)
    );

    assign cpu_gnt   = ~reset & cpu_req & sel_cpu;
    assign host_gnt  = ~reset & host_req & sel_host;
    assign cpu_stall = ~reset & ((cpu_req & ~cpu_gnt) | host_lock);

    assign accept    = cpu_gnt | host_gnt;
    assign acc_port  = host_gnt ? PORT_HOST : PORT_CPU;
    assign acc_we    = host_gnt ? host_we    : cpu_we;
    assign acc_adr   = host_gnt ? host_adr   : cpu_adr;
    assign acc_wdata = host_gnt ? host_wdata : cpu_wdata;

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pointer <= PORT_CPU;
        end else if (accept) begin
            pointer <= other_port(acc_port);
        end
    end
`else
    // A pointer stuck on host turns contention resolution into fixed host priority.
    assign pointer = PORT_HOST;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_we    <= 1'b0;
            mem_adr   <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= accept & acc_we;
            if (accept) begin
                mem_adr   <= acc_adr;
                mem_wdata <= acc_wdata;
            end
        end
    end

    // tag0 rides with the memory command, tag1 with the memory's read data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag0 <= '0;
            tag1 <= '0;
        end else begin
            tag0 <= '{valid: accept, port: acc_port, is_read: ~acc_we};
            tag1 <= tag0;
        end
    end

    assign cpu_rvalid  = tag1.valid & tag1.is_read & (tag1.port == PORT_CPU);
    assign host_rvalid = tag1.valid & tag1.is_read & (tag1.port == PORT_HOST);
    assign rdata       = (tag1.valid & tag1.is_read) ? mem_rdata : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else if (host_lock) begin
            state <= LOCK;
        end else if (state == LOCK) begin
            state <= IDLE;
        end else if (cpu_gnt) begin
            state <= CPU;
        end else if (host_gnt) begin
            state <= HOST;
        end else begin
            state <= IDLE;
        end
    end

endmodule
